// File: rtl/hci_bank_rr_arbiter.sv
// Purpose: shares one single-ported TCDM bank among N_REQ HCI requesters, round-robin with starvation override.
// Latency: grant is combinational in the request cycle; read data returns BANK_LAT cycles after the grant cycle.
// Backpressure: bank_gnt=0 stalls every requester (no gnt); r_valid cannot be stalled, requesters must sink it.
module hci_bank_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BANK_LAT  = 1,
  parameter int MAX_STALL = 8,
  parameter int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          wen,
  input  logic [N_REQ*AW-1:0]       add,
  input  logic [N_REQ*DW-1:0]       data,
  input  logic [N_REQ*(DW/8)-1:0]   be,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          r_valid,
  output logic [DW-1:0]             r_data,
  output logic                      bank_req,
  output logic                      bank_wen,
  output logic [AW-1:0]             bank_add,
  output logic [DW-1:0]             bank_data,
  output logic [DW/8-1:0]           bank_be,
  input  logic                      bank_gnt,
  input  logic [DW-1:0]             bank_rdata,
  output logic                      starve_grant
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(MAX_STALL + 1);
  localparam logic [CW-1:0] STALL_MAX = CW'(MAX_STALL);

  // Arbitration state
  logic [IDW-1:0] ptr_q;
  logic [CW-1:0]  wait_cnt_q [N_REQ];

  // Response pipe: one {valid, id} entry per cycle of bank latency
  logic           pipe_vld_q [BANK_LAT];
  logic [IDW-1:0] pipe_id_q  [BANK_LAT];

  // Winner selection
  logic [N_REQ-1:0] starve_vec;
  logic [N_REQ-1:0] hi_mask;
  logic [N_REQ-1:0] hi_req;
  logic             starve_hit;
  logic [IDW-1:0]   starve_idx;
  logic [IDW-1:0]   rr_idx;
  logic [IDW-1:0]   winner;
  logic             handshake;

  // Lowest set bit of a request vector; 0 when the vector is empty.
  function automatic logic [IDW-1:0] lowest_idx(input logic [N_REQ-1:0] v);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = IDW'(i);
    end
    return idx;
  endfunction

  // Flag requesters that have waited the full stall budget and still request.
  always_comb begin
    starve_vec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      starve_vec[i] = req[i] && (wait_cnt_q[i] == STALL_MAX);
    end
  end

  // Round-robin: prefer requests at or above the pointer, then wrap to the lowest.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      hi_mask[i] = (IDW'(i) >= ptr_q);
    end
    hi_req = req & hi_mask;
    rr_idx = (|hi_req) ? lowest_idx(hi_req) : lowest_idx(req);
  end

  // Starvation override beats the round-robin choice.
  always_comb begin
    starve_hit = |starve_vec;
    starve_idx = lowest_idx(starve_vec);
    winner     = starve_hit ? starve_idx : rr_idx;
  end

  // Bank request and per-requester grant; everything is forced low while in reset.
  always_comb begin
    bank_req     = (|req) && !rst;
    handshake    = bank_req && bank_gnt;
    starve_grant = starve_hit && bank_gnt && !rst;
    gnt          = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt[i] = handshake && (winner == IDW'(i));
    end
  end

  // Steer the winner's command fields onto the bank port.
  always_comb begin
    bank_wen  = 1'b0;
    bank_add  = '0;
    bank_data = '0;
    bank_be   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == IDW'(i)) begin
        bank_wen  = wen[i];
        bank_add  = add[i*AW +: AW];
        bank_data = data[i*DW +: DW];
        bank_be   = be[i*BW +: BW];
      end
    end
  end

  // Pointer moves past the winner after every accepted transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (handshake) begin
      if (winner == IDW'(N_REQ - 1)) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= winner + IDW'(1);
      end
    end
  end

  // Wait counters count ungranted request cycles, saturating at the stall budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        wait_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i] && !gnt[i]) begin
          if (wait_cnt_q[i] != STALL_MAX) begin
            wait_cnt_q[i] <= wait_cnt_q[i] + CW'(1);
          end
        end else begin
          wait_cnt_q[i] <= '0;
        end
      end
    end
  end

  // Shift accepted reads through the latency pipe; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < BANK_LAT; s++) begin
        pipe_vld_q[s] <= 1'b0;
        pipe_id_q[s]  <= '0;
      end
    end else begin
      pipe_vld_q[0] <= handshake && bank_wen;
      pipe_id_q[0]  <= winner;
      for (int s = 1; s < BANK_LAT; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_id_q[s]  <= pipe_id_q[s-1];
      end
    end
  end

  // Route the returning bank data to the requester that issued the read.
  always_comb begin
    r_valid = '0;
    r_data  = '0;
    if (pipe_vld_q[BANK_LAT-1]) begin
      r_data = bank_rdata;
      for (int i = 0; i < N_REQ; i++) begin
        r_valid[i] = (pipe_id_q[BANK_LAT-1] == IDW'(i));
      end
    end
  end

endmodule

// File: tb/tb_hci_bank_rr_arbiter.sv
`timescale 1ns/1ps
module tb_hci_bank_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared requester-side stimulus
  logic [N-1:0]    req, wen;
  logic [N*AW-1:0] add;
  logic [N*DW-1:0] data;
  logic [N*BW-1:0] be;
  logic            bank_gnt;

  // Instance with BANK_LAT=1
  logic [N-1:0]  gnt_l1, r_valid_l1;
  logic [DW-1:0] r_data_l1, bank_data_l1, bank_rdata_l1;
  logic          bank_req_l1, bank_wen_l1, starve_l1;
  logic [AW-1:0] bank_add_l1;
  logic [BW-1:0] bank_be_l1;

  // Instance with BANK_LAT=3
  logic [N-1:0]  gnt_l3, r_valid_l3;
  logic [DW-1:0] r_data_l3, bank_data_l3, bank_rdata_l3;
  logic          bank_req_l3, bank_wen_l3, starve_l3;
  logic [AW-1:0] bank_add_l3;
  logic [BW-1:0] bank_be_l3;

  hci_bank_rr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .BANK_LAT(1), .MAX_STALL(MS)) u_lat1 (
    .clk(clk), .rst(rst), .req(req), .wen(wen), .add(add), .data(data), .be(be),
    .gnt(gnt_l1), .r_valid(r_valid_l1), .r_data(r_data_l1),
    .bank_req(bank_req_l1), .bank_wen(bank_wen_l1), .bank_add(bank_add_l1),
    .bank_data(bank_data_l1), .bank_be(bank_be_l1), .bank_gnt(bank_gnt),
    .bank_rdata(bank_rdata_l1), .starve_grant(starve_l1)
  );

  hci_bank_rr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .BANK_LAT(3), .MAX_STALL(MS)) u_lat3 (
    .clk(clk), .rst(rst), .req(req), .wen(wen), .add(add), .data(data), .be(be),
    .gnt(gnt_l3), .r_valid(r_valid_l3), .r_data(r_data_l3),
    .bank_req(bank_req_l3), .bank_wen(bank_wen_l3), .bank_add(bank_add_l3),
    .bank_data(bank_data_l3), .bank_be(bank_be_l3), .bank_gnt(bank_gnt),
    .bank_rdata(bank_rdata_l3), .starve_grant(starve_l3)
  );

  typedef struct {
    int          id;
    logic [DW-1:0] data;
    int          due;
  } rsp_t;

  rsp_t exp_l1[$], exp_l3[$];   // expected responses per instance
  rsp_t bq_l1[$],  bq_l3[$];    // bank-side read data waiting to be returned

  logic [DW-1:0] mem [64];
  int m_ptr;
  int m_wait [N];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  // Staged next-cycle inputs, applied just after the rising edge
  logic [N-1:0]    nx_req, nx_wen;
  logic [N*AW-1:0] nx_add;
  logic [N*DW-1:0] nx_data;
  logic [N*BW-1:0] nx_be;
  logic            nx_gnt, nx_rst;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t cyc=%0d got=%0h want=%0h", nm, $time, cyc, act, exp);
    end
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < N; i++) begin
      nx_add[i*AW +: AW]  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      nx_data[i*DW +: DW] = $urandom;
      nx_be[i*BW +: BW]   = 4'($urandom);
    end
  endtask

  task automatic mon(input string nm, input logic [N-1:0] rv, input logic [DW-1:0] rd,
                     input bit have, input rsp_t e);
    if (have) begin
      chk({nm, "_rvalid"}, 64'(rv), 64'(1) << e.id);
      chk({nm, "_rdata"},  64'(rd), 64'(e.data));
      chk({nm, "_rcycle"}, 64'(cyc), 64'(e.due));
    end else begin
      chk({nm, "_no_rvalid"}, 64'(rv), 64'(0));
      chk({nm, "_rdata_idle"}, 64'(rd), 64'(0));
    end
  endtask

  // Response monitors: pop an expectation whenever the DUT responds or one falls due.
  always @(negedge clk) begin : mon_l1
    rsp_t e;
    bit   have;
    have = 1'b0;
    e    = '{0, '0, 0};
    if (rst !== 1'b0 && cyc < 2) begin
      have = 1'b0;
    end
    if (rst === 1'b0 && exp_l1.size() > 0 && (r_valid_l1 != '0 || exp_l1[0].due <= cyc)) begin
      e    = exp_l1.pop_front();
      have = 1'b1;
    end
    mon("l1", r_valid_l1, r_data_l1, have, e);
  end

  always @(negedge clk) begin : mon_l3
    rsp_t e;
    bit   have;
    have = 1'b0;
    e    = '{0, '0, 0};
    if (rst === 1'b0 && exp_l3.size() > 0 && (r_valid_l3 != '0 || exp_l3[0].due <= cyc)) begin
      e    = exp_l3.pop_front();
      have = 1'b1;
    end
    mon("l3", r_valid_l3, r_data_l3, have, e);
  end

  // One clock of stimulus, bank model and reference-model evaluation.
  task automatic step();
    int            win;
    bit            st, hs;
    logic [N-1:0]  exp_g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] b;
    rsp_t          t;
    @(posedge clk);
    #1;
    req = nx_req; wen = nx_wen; add = nx_add; data = nx_data; be = nx_be;
    bank_gnt = nx_gnt; rst = nx_rst;
    bank_rdata_l1 = $urandom;
    if (bq_l1.size() > 0 && bq_l1[0].due == cyc) begin
      t = bq_l1.pop_front();
      bank_rdata_l1 = t.data;
    end
    bank_rdata_l3 = $urandom;
    if (bq_l3.size() > 0 && bq_l3[0].due == cyc) begin
      t = bq_l3.pop_front();
      bank_rdata_l3 = t.data;
    end
    @(negedge clk);
    if (rst) begin
      chk("rst_gnt_l1", 64'(gnt_l1), 64'(0));
      chk("rst_gnt_l3", 64'(gnt_l3), 64'(0));
      chk("rst_bank_req_l1", 64'(bank_req_l1), 64'(0));
      chk("rst_bank_req_l3", 64'(bank_req_l3), 64'(0));
      chk("rst_starve_l1", 64'(starve_l1), 64'(0));
      chk("rst_starve_l3", 64'(starve_l3), 64'(0));
      m_ptr = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      exp_l1.delete(); exp_l3.delete(); bq_l1.delete(); bq_l3.delete();
      return;
    end
    win = -1;
    st  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (win < 0 && req[i] && m_wait[i] == MS) begin
        win = i;
        st  = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    end
    hs    = bank_gnt && (win >= 0);
    exp_g = '0;
    if (hs) exp_g[win] = 1'b1;
    chk("gnt_l1", 64'(gnt_l1), 64'(exp_g));
    chk("gnt_l3", 64'(gnt_l3), 64'(exp_g));
    chk("starve_l1", 64'(starve_l1), 64'(st && bank_gnt));
    chk("starve_l3", 64'(starve_l3), 64'(st && bank_gnt));
    chk("bank_req_l1", 64'(bank_req_l1), 64'(req != '0));
    chk("bank_req_l3", 64'(bank_req_l3), 64'(req != '0));
    if (win >= 0) begin
      a = add[win*AW +: AW];
      d = data[win*DW +: DW];
      b = be[win*BW +: BW];
      chk("bank_wen", 64'(bank_wen_l1), 64'(wen[win]));
      chk("bank_add", 64'(bank_add_l1), 64'(a));
      chk("bank_add_l3", 64'(bank_add_l3), 64'(a));
      chk("bank_data", 64'(bank_data_l1), 64'(d));
      chk("bank_be", 64'(bank_be_l3), 64'(b));
      if (hs) begin
        if (wen[win]) begin
          t = '{win, mem[a[7:2]], cyc + 1};
          exp_l1.push_back(t); bq_l1.push_back(t);
          t.due = cyc + 3;
          exp_l3.push_back(t); bq_l3.push_back(t);
        end else begin
          for (int y = 0; y < BW; y++) begin
            if (b[y]) mem[a[7:2]][y*8 +: 8] = d[y*8 +: 8];
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req[i] && !exp_g[i]) m_wait[i] = (m_wait[i] < MS) ? m_wait[i] + 1 : MS;
      else                     m_wait[i] = 0;
    end
    if (hs) m_ptr = (win + 1) % N;
  endtask

  task automatic one(input int id, input bit rd);
    nx_req = '0; nx_wen = '0;
    nx_req[id] = 1'b1;
    nx_wen[id] = rd;
    rand_lanes();
    step();
  endtask

  initial begin
    rst = 1'b0; req = '0; wen = '0; add = '0; data = '0; be = '0; bank_gnt = 1'b0;
    bank_rdata_l1 = '0; bank_rdata_l3 = '0;
    nx_req = '0; nx_wen = '0; nx_add = '0; nx_data = '0; nx_be = '0; nx_gnt = 1'b0; nx_rst = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA5000000 + 32'(i * 257);
    mem[16] = 32'hDEADBEEF;
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
    #2 rst = 1'b1;
    repeat (3) step();
    nx_rst = 1'b0;

    // Single read from requester 2 at 0x40
    nx_gnt = 1'b1; nx_req = 4'b0100; nx_wen = 4'b0100; rand_lanes();
    nx_add[2*AW +: AW] = 32'h40;
    step();
    chk("t1_gnt", 64'(gnt_l1), 64'(4'b0100));
    nx_req = '0;
    repeat (4) step();

    // Everyone requests with the bank always ready
    nx_req = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      nx_wen = 4'($urandom); rand_lanes(); step();
    end
    nx_req = '0; step();

    // Bank stalls ten cycles while 1 and 3 wait
    nx_req = 4'b1010; nx_wen = 4'b1010; nx_gnt = 1'b0;
    repeat (10) begin rand_lanes(); step(); end
    nx_gnt = 1'b1; step();
    chk("t3_gnt_a", 64'(gnt_l1), 64'(4'b0010));
    chk("t3_starve_a", 64'(starve_l1), 64'(1));
    step();
    chk("t3_gnt_b", 64'(gnt_l3), 64'(4'b1000));
    chk("t3_starve_b", 64'(starve_l3), 64'(1));
    nx_req = '0; repeat (2) step();

    // Alternating reads 0/1 interleaved with a write from 2
    one(0, 1'b1); one(1, 1'b1); one(2, 1'b0); one(0, 1'b1); one(1, 1'b1);
    nx_req = '0; repeat (5) step();

    // Reset one cycle after a read grant
    one(0, 1'b1);
    nx_rst = 1'b1; nx_req = 4'b1111; step();
    chk("t5_rvalid_l3", 64'(r_valid_l3), 64'(0));
    chk("t5_rdata_l3", 64'(r_data_l3), 64'(0));
    step();
    nx_rst = 1'b0; nx_req = 4'b1111; nx_gnt = 1'b1; step();
    chk("t5_gnt_after_rst", 64'(gnt_l3), 64'(4'b0001));
    nx_req = '0; repeat (5) step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      nx_req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) nx_req = '0;
      nx_wen = 4'($urandom);
      nx_gnt = ($urandom_range(0, 3) != 0);
      nx_rst = ($urandom_range(0, 499) == 0);
      rand_lanes();
      step();
    end

    nx_rst = 1'b0; nx_req = '0; nx_gnt = 1'b1;
    repeat (6) step();
    chk("drain_l1", 64'(exp_l1.size()), 64'(0));
    chk("drain_l3", 64'(exp_l3.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
